// File: rtl/jt6295_chseq.sv
// Four-channel round-robin sample address sequencer feeding the ADPCM decoder.
// Optional JT6295_MISSCNT_EN adds a saturating miss_cnt output for late ROM replies.
module jt6295_chseq (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen4,
  input  logic [17:0] start_addr,
  input  logic [17:0] stop_addr,
  input  logic [3:0]  att,
  input  logic [3:0]  start,
  input  logic [3:0]  stop,
  output logic [3:0]  busy,
  output logic [3:0]  ack,
  output logic        zero,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic [3:0]  dec_data,
  output logic [1:0]  dec_ch,
  output logic [3:0]  dec_att,
  output logic        dec_en
`ifdef JT6295_MISSCNT_EN
  ,
  output logic [7:0]  miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_reg;
  logic [1:0]  slot_reg;
  logic [1:0]  slot_next;
  logic [18:0] naddr_reg [4];
  logic [17:0] saddr_reg [4];
  logic [3:0]  catt_reg  [4];

  logic [3:0]  pend;
  logic [1:0]  sel;
  logic        sel_valid;
  logic [18:0] cur_naddr;
  logic        drop;

  assign slot_next = slot_reg + 2'd1;
  assign cur_naddr = naddr_reg[slot_reg];
  // A fetch is abandoned as soon as its channel is stopped or no longer playing.
  assign drop      = stop[slot_reg] | ~busy[slot_reg];
  assign pend      = start & ~ack;

  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) begin
        sel       = 2'(i);
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      slot_reg  <= 2'd3;
      busy      <= '0;
      ack       <= '0;
      zero      <= 1'b0;
      rom_addr  <= '0;
      dec_data  <= '0;
      dec_ch    <= '0;
      dec_att   <= '0;
      dec_en    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        naddr_reg[i] <= '0;
        saddr_reg[i] <= '0;
        catt_reg[i]  <= '0;
      end
`ifdef JT6295_MISSCNT_EN
      miss_cnt <= '0;
`endif
    end else begin
      ack    <= '0;
      zero   <= 1'b0;
      dec_en <= 1'b0;

      if (sel_valid) begin
        ack[sel] <= 1'b1;
        if (!busy[sel] && !stop[sel]) begin
          naddr_reg[sel] <= {start_addr, 1'b0};
          saddr_reg[sel] <= stop_addr;
          catt_reg[sel]  <= att;
          busy[sel]      <= 1'b1;
        end
      end

      if (cen4) begin
        slot_reg <= slot_next;
        zero     <= (slot_next == 2'd0);
`ifdef JT6295_MISSCNT_EN
        if (state_reg == WAIT && miss_cnt != 8'hFF)
          miss_cnt <= miss_cnt + 8'd1;
`endif
        if (busy[slot_next]) begin
          rom_addr  <= naddr_reg[slot_next][18:1];
          state_reg <= REQ;
        end else begin
          state_reg <= IDLE;
        end
      end else begin
        case (state_reg)
          REQ:  state_reg <= drop ? IDLE : WAIT;
          WAIT: begin
            if (drop) begin
              state_reg <= IDLE;
            end else if (rom_ok) begin
              dec_data            <= cur_naddr[0] ? rom_data[3:0] : rom_data[7:4];
              dec_ch              <= slot_reg;
              dec_att             <= catt_reg[slot_reg];
              dec_en              <= 1'b1;
              naddr_reg[slot_reg] <= cur_naddr + 19'd1;
              if (cur_naddr[18:1] == saddr_reg[slot_reg] && cur_naddr[0])
                busy[slot_reg] <= 1'b0;
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end

      // Stop has the final word over start and end-of-sample.
      for (int i = 0; i < 4; i++)
        if (stop[i]) busy[i] <= 1'b0;
    end
  end

endmodule

// File: doc/jt6295_chseq.md
Name: jt6295_chseq

Overview:
- Four-channel sample address sequencer sitting directly downstream of the phrase-table controller.
- Accepts the start/stop requests and the start address, stop address and attenuation that the controller resolves, and returns busy/ack/zero to it.
- Walks each active channel's sample data in ROM one nibble per channel slot, time-multiplexed round robin, and hands nibbles to the ADPCM decoder.

Parameters:
- none

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active high
- cen4  input  1  slot clock enable; one channel slot per cen4 pulse
- start_addr  input  18  byte start address for the channel being started
- stop_addr  input  18  byte stop address, inclusive
- att  input  4  attenuation for the channel being started
- start  input  4  one-hot start request, level, held until acked
- stop  input  4  stop request mask, level
- busy  output  4  channel playing
- ack  output  4  one-clk pulse acknowledging start[i]
- zero  output  1  one-clk pulse when slot counter wraps to channel 0
- rom_addr  output  18  sample ROM byte address
- rom_data  input  8  sample ROM data
- rom_ok  input  1  rom_data valid for current rom_addr
- dec_data  output  4  ADPCM nibble
- dec_ch  output  2  channel of dec_data
- dec_att  output  4  attenuation of dec_ch
- dec_en  output  1  one-clk pulse, dec_* valid

Behaviour:
- Reset: busy=0, ack=0, zero=0, rom_addr=0, dec_data=0, dec_ch=0, dec_att=0, dec_en=0, slot=3, all channel registers 0, no fetch pending. Reset mid-fetch abandons the fetch; a late rom_ok is ignored.
- Per channel i: naddr[18:0] nibble address (byte address = naddr[18:1], naddr[0]=0 selects high nibble), saddr[17:0], catt[3:0], busy[i].
- Start handling, any clk:
  - Lowest-index set bit i of start&~ack is served: ack[i]=1 for exactly one clk.
  - In the same clk, if busy[i]=0 and stop[i]=0: naddr={start_addr,1'b0}, saddr=stop_addr, catt=att, busy[i]=1.
  - If busy[i]=1 or stop[i]=1, the request is acked but dropped (channel unchanged).
  - At most one ack per clk; other pending starts are served on subsequent clks.
- Stop: stop[i]=1 clears busy[i] on the next clk. Stop wins over end-of-sample and over start.
- Slot FSM, states IDLE/REQ/WAIT:
  - Every cen4: slot<=slot+1 (2-bit wrap).
  - zero=1 for one clk when slot becomes 0.
  - If busy[slot_new]: rom_addr<=naddr[18:1] and go to REQ; otherwise IDLE.
  - REQ lasts one clk; rom_ok is ignored in REQ (address settling). Then WAIT.
  - WAIT, rom_ok=1 and no cen4 in the same clk: dec_data = naddr[0] ? rom_data[3:0] : rom_data[7:4]; dec_ch=slot, dec_att=catt, dec_en=1 for one clk; naddr<=naddr+1.
    - If naddr[18:1]==saddr and naddr[0]==1, busy[slot]<=0 (last nibble emitted).
    - Go to IDLE.
  - WAIT, cen4 arrives before rom_ok (miss): no dec_en, naddr unchanged (nibble retried next round); the new slot's FSM entry proceeds normally.
  - Channel stopped while in REQ/WAIT: fetch abandoned, no dec_en.
- naddr increments with 19-bit wrap; stop_addr<start_addr plays through ROM wrap-around until saddr is reached.
- Latency: ack 1 clk after start; first dec_en for a channel no earlier than its next slot + 2 clks.

Optional Feature:
- Macro JT6295_MISSCNT_EN.
- Defined: adds output port miss_cnt[7:0]; reset 0; increments (saturating at 255) on every WAIT→cen4 miss.
- Undefined: port and counter absent; miss behaviour otherwise identical.

Test Plan:
- Reset mid-WAIT, rom_ok pulsed after reset -> busy=0, dec_en never asserted, all outputs 0.
- start=0001, start_addr=0x00100, stop_addr=0x00101, rom_ok 2 clks after address, data 0xAB,0xCD -> ack[0] one clk; dec_data A,B,C,D on ch0 across four slot-0 rounds; busy[0] clears after D; rom_addr 0x00100,0x00100,0x00101,0x00101.
- start=0110 simultaneously -> ack[1] then ack[2] on consecutive clks; both busy.
- Channel 3 busy, start=1000 with new start_addr -> acked, naddr/saddr unchanged, playback continues.
- stop=0001 during WAIT of ch0 -> busy[0]=0 next clk, no dec_en for that slot.
- rom_ok withheld past cen4 for ch2 -> no dec_en, same nibble refetched next round; with JT6295_MISSCNT_EN, miss_cnt 0→1.
